// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative multiply/divide unit.
// Signed operation is selected at build time with MULDIV_SIGNED_EN.
package muldiv_pkg;
  localparam int MULDIV_WIDTH = 32;

  localparam logic OP_MULT = 1'b0;
  localparam logic OP_DIV  = 1'b1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2
  } state_t;
endpackage

// File: rtl/muldiv_sign.sv
// Sign handling around the unsigned iteration core.
// With MULDIV_SIGNED_EN defined, operands are reduced to magnitudes on launch
// and the raw result is negated as needed in FIX. Without it, this block is a
// pass-through so the core always sees plain unsigned values.
module muldiv_sign
  import muldiv_pkg::*;
#(
  parameter int WIDTH = MULDIV_WIDTH
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] a_mag,
  output logic [WIDTH-1:0] b_mag,
  output logic             a_neg,
  output logic             b_neg,
  input  logic             op,
  input  logic             neg_a,
  input  logic             neg_b,
  input  logic [WIDTH-1:0] hi_raw,
  input  logic [WIDTH-1:0] lo_raw,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);
`ifdef MULDIV_SIGNED_EN
  assign a_neg = a[WIDTH-1];
  assign b_neg = b[WIDTH-1];
  assign a_mag = a_neg ? -a : a;
  assign b_mag = b_neg ? -b : b;

  // product sign = sign xor; quotient likewise; remainder follows dividend
  always_comb begin
    hi = hi_raw;
    lo = lo_raw;
    if (op == OP_MULT) begin
      if (neg_a ^ neg_b) {hi, lo} = -{hi_raw, lo_raw};
    end else begin
      if (neg_a ^ neg_b) lo = -lo_raw;
      if (neg_a)         hi = -hi_raw;
    end
  end
`else
  logic unused_sign;

  assign a_neg = 1'b0;
  assign b_neg = 1'b0;
  assign a_mag = a;
  assign b_mag = b;
  assign hi    = hi_raw;
  assign lo    = lo_raw;
  assign unused_sign = ^{op, neg_a, neg_b};
`endif
endmodule

// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit with HI/LO result registers.
// One shift-add / restoring shift-subtract step per RUN cycle, then one FIX
// cycle for sign correction. Build option: MULDIV_SIGNED_EN (two's complement).
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int WIDTH = MULDIV_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             op,
  input  logic [WIDTH-1:0] srca,
  input  logic [WIDTH-1:0] srcb,
  input  logic             mfhi,
  input  logic             mflo,
  output logic             busy,
  output logic             done,
  output logic             stall,
  output logic [WIDTH-1:0] result
);
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  state_t             state;
  logic [CW-1:0]      cnt;
  logic [2*WIDTH-1:0] acc;    // mult: {partial, multiplier}; div: {rem, dividend/quot}
  logic [WIDTH-1:0]   opnd;   // mult: multiplicand magnitude; div: divisor magnitude
  logic [WIDTH-1:0]   a_raw;  // dividend as issued, returned in HI on divide-by-zero
  logic               op_r, neg_a, neg_b;
  logic [WIDTH-1:0]   hi, lo;

  logic [WIDTH-1:0]   a_mag, b_mag, hi_fix, lo_fix;
  logic               a_neg, b_neg;

  logic [WIDTH:0]     msum, dtrial, ddiff;
  logic               dge;
  logic [2*WIDTH-1:0] acc_nxt;

  muldiv_sign #(.WIDTH(WIDTH)) u_sign (
    .a      (srca),
    .b      (srcb),
    .a_mag  (a_mag),
    .b_mag  (b_mag),
    .a_neg  (a_neg),
    .b_neg  (b_neg),
    .op     (op_r),
    .neg_a  (neg_a),
    .neg_b  (neg_b),
    .hi_raw (acc[2*WIDTH-1:WIDTH]),
    .lo_raw (acc[WIDTH-1:0]),
    .hi     (hi_fix),
    .lo     (lo_fix)
  );

  // one iteration step: add-and-shift-right for mult, trial-subtract-shift-left for div
  always_comb begin
    msum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, (acc[0] ? opnd : {WIDTH{1'b0}})};
    dtrial = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
    dge    = dtrial >= {1'b0, opnd};
    ddiff  = dtrial - {1'b0, opnd};
    if (op_r == OP_MULT)
      acc_nxt = {msum, acc[WIDTH-1:1]};
    else
      acc_nxt = {(dge ? ddiff[WIDTH-1:0] : dtrial[WIDTH-1:0]), acc[WIDTH-2:0], dge};
  end

  // control FSM, iteration registers and HI/LO; done is a registered pulse
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
      acc   <= '0;
      opnd  <= '0;
      a_raw <= '0;
      op_r  <= OP_MULT;
      neg_a <= 1'b0;
      neg_b <= 1'b0;
      hi    <= '0;
      lo    <= '0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (start) begin
          op_r  <= op;
          a_raw <= srca;
          neg_a <= a_neg;
          neg_b <= b_neg;
          cnt   <= CW'(WIDTH - 1);
          if (op == OP_DIV) begin
            acc  <= {{WIDTH{1'b0}}, a_mag};
            opnd <= b_mag;
          end else begin
            acc  <= {{WIDTH{1'b0}}, b_mag};
            opnd <= a_mag;
          end
          state <= RUN;
        end
        RUN: begin
          acc <= acc_nxt;
          if (cnt == '0) state <= FIX;
          else           cnt   <= cnt - 1'b1;
        end
        FIX: begin
          if (op_r == OP_DIV && opnd == '0) begin
            hi <= a_raw;
            lo <= '1;
          end else begin
            hi <= hi_fix;
            lo <= lo_fix;
          end
          done  <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign busy   = (state != IDLE);
  assign stall  = busy & (start | mfhi | mflo);
  assign result = mfhi ? hi : lo;
endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed table, corner sequences,
// randomized operations against an arithmetic reference model.
module tb_muldiv_unit;
  import muldiv_pkg::*;

  localparam int W = 32;
  localparam int LAT = W + 2;

  logic         clk = 1'b0;
  logic         reset, start, op, mfhi, mflo;
  logic [W-1:0] srca, srcb;
  logic         busy, done, stall;
  logic [W-1:0] result;

  int checks = 0;
  int failures = 0;

  logic [W-1:0] cur_hi = '0, cur_lo = '0;

  typedef struct {
    string        name;
    logic         op;
    logic [W-1:0] a, b, hi, lo;
  } vec_t;

  muldiv_unit #(.WIDTH(W)) dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .op     (op),
    .srca   (srca),
    .srcb   (srcb),
    .mfhi   (mfhi),
    .mflo   (mflo),
    .busy   (busy),
    .done   (done),
    .stall  (stall),
    .result (result)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  // reference: plain arithmetic on the operands
  function automatic void model(input logic o, input logic [W-1:0] a, input logic [W-1:0] b,
                                output logic [W-1:0] hi, output logic [W-1:0] lo);
    longint sa, sb, q, r;
    logic [63:0] p, qq, rr;
`ifdef MULDIV_SIGNED_EN
    sa = $signed(a);
    sb = $signed(b);
`else
    sa = {32'b0, a};
    sb = {32'b0, b};
`endif
    if (o == OP_DIV) begin
      if (b == '0) begin
        hi = a;
        lo = '1;
      end else begin
        q = sa / sb;
        r = sa % sb;
        qq = q;
        rr = r;
        lo = qq[W-1:0];
        hi = rr[W-1:0];
      end
    end else begin
      p = sa * sb;
      hi = p[63:32];
      lo = p[31:0];
    end
  endfunction

  task automatic read_hilo(output logic [W-1:0] h, output logic [W-1:0] l);
    mfhi = 1'b1; mflo = 1'b0;
    #1 h = result;
    mfhi = 1'b0; mflo = 1'b1;
    #1 l = result;
    mflo = 1'b0;
    #1;
  endtask

  // count negedges after the launch edge until done is seen (bounded)
  task automatic wait_done(inout int n);
    while (!done && n < LAT + 20) begin
      @(negedge clk);
      n++;
    end
  endtask

  // launch, wait, check latency, HI, LO and single-cycle done
  task automatic run_op(input string nm, input logic o, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic [W-1:0] eh, input logic [W-1:0] el);
    int n;
    logic [W-1:0] h, l;
    @(negedge clk);
    start = 1'b1; op = o; srca = a; srcb = b;
    @(negedge clk);
    start = 1'b0;
    n = 1;
    wait_done(n);
    chk({nm, " latency"}, n, LAT);
    read_hilo(h, l);
    chk({nm, " hi"}, h, eh);
    chk({nm, " lo"}, l, el);
    cur_hi = eh;
    cur_lo = el;
    @(negedge clk);
    chk({nm, " done pulse width"}, done, 1'b0);
  endtask

  initial begin
    vec_t vt[$];
    logic [W-1:0] eh, el, h, l;
    int n, cnt;

    reset = 1'b1; start = 1'b1; op = OP_MULT; srca = '0; srcb = '0; mfhi = 1'b0; mflo = 1'b1;

    // reset state
    #2;
    chk("rst busy", busy, 1'b0);
    chk("rst done", done, 1'b0);
    chk("rst stall", stall, 1'b0);
    chk("rst lo", result, '0);
    mfhi = 1'b1;
    #1 chk("rst hi", result, '0);
    mfhi = 1'b0; mflo = 1'b0; start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("post-rst busy", busy, 1'b0);

    // directed table
`ifdef MULDIV_SIGNED_EN
    vt.push_back('{"smul -3*5", OP_MULT, 32'hFFFFFFFD, 32'd5, 32'hFFFFFFFF, 32'hFFFFFFF1});
    vt.push_back('{"sdiv -7/2", OP_DIV, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD});
    vt.push_back('{"sdiv 7/-2", OP_DIV, 32'd7, 32'hFFFFFFFE, 32'd1, 32'hFFFFFFFD});
    vt.push_back('{"smul -1*-1", OP_MULT, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0, 32'd1});
`else
    vt.push_back('{"mul max*max", OP_MULT, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001});
    vt.push_back('{"mul shift", OP_MULT, 32'h12345678, 32'h10, 32'h1, 32'h23456780});
    vt.push_back('{"div max/1", OP_DIV, 32'hFFFFFFFF, 32'd1, 32'd0, 32'hFFFFFFFF});
`endif
    vt.push_back('{"div 100/7", OP_DIV, 32'd100, 32'd7, 32'd2, 32'd14});
    vt.push_back('{"div 5/0", OP_DIV, 32'd5, 32'd0, 32'd5, 32'hFFFFFFFF});
    vt.push_back('{"mul 0*x", OP_MULT, 32'd0, 32'h89ABCDEF, 32'd0, 32'd0});
    foreach (vt[i]) run_op(vt[i].name, vt[i].op, vt[i].a, vt[i].b, vt[i].hi, vt[i].lo);

    // mflo + second start during RUN: stall, old LO visible, start ignored
    model(OP_MULT, 32'h00012345, 32'h00000321, eh, el);
    @(negedge clk);
    start = 1'b1; op = OP_MULT; srca = 32'h00012345; srcb = 32'h00000321;
    @(negedge clk);
    start = 1'b0;
    n = 1;
    repeat (4) begin @(negedge clk); n++; end
    start = 1'b1; op = OP_DIV; srca = 32'd9; srcb = 32'd3; mflo = 1'b1;
    #1;
    chk("run stall", stall, 1'b1);
    chk("run old lo", result, cur_lo);
    @(negedge clk);
    n++;
    start = 1'b0;
    chk("run stall mflo only", stall, 1'b1);
    wait_done(n);
    chk("ignored start latency", n, LAT);
    #1;
    chk("done stall", stall, 1'b0);
    chk("done new lo", result, el);
    mflo = 1'b0;
    cur_hi = eh; cur_lo = el;
    cnt = 0;
    repeat (LAT + 4) begin @(negedge clk); if (done) cnt++; end
    chk("extra done pulses", cnt, 0);
    chk("idle after single op", busy, 1'b0);

    // back-to-back: start on the done cycle is accepted
    model(OP_DIV, 32'd1000, 32'd33, eh, el);
    @(negedge clk);
    start = 1'b1; op = OP_MULT; srca = 32'd6; srcb = 32'd7;
    @(negedge clk);
    start = 1'b0;
    n = 1;
    wait_done(n);
    chk("b2b first latency", n, LAT);
    start = 1'b1; op = OP_DIV; srca = 32'd1000; srcb = 32'd33;
    #1 chk("b2b no stall", stall, 1'b0);
    @(negedge clk);
    start = 1'b0;
    chk("b2b accepted", busy, 1'b1);
    n = 1;
    wait_done(n);
    chk("b2b second latency", n, LAT);
    read_hilo(h, l);
    chk("b2b hi", h, eh);
    chk("b2b lo", l, el);
    cur_hi = eh; cur_lo = el;

    // reset mid-RUN
    run_op("pre-reset 100/7", OP_DIV, 32'd100, 32'd7, 32'd2, 32'd14);
    @(negedge clk);
    start = 1'b1; op = OP_MULT; srca = 32'hDEAD; srcb = 32'hBEEF;
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    mflo = 1'b1;
    #1 chk("pre-reset stall", stall, 1'b1);
    reset = 1'b1;
    #1;
    chk("mid reset busy", busy, 1'b0);
    chk("mid reset stall", stall, 1'b0);
    chk("mid reset lo", result, '0);
    mflo = 1'b0; mfhi = 1'b1;
    #1 chk("mid reset hi", result, '0);
    mfhi = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    cnt = 0;
    repeat (LAT + 4) begin @(negedge clk); if (done) cnt++; end
    chk("no done after reset", cnt, 0);
    chk("idle after reset", busy, 1'b0);
    cur_hi = '0; cur_lo = '0;

    // randomized operations vs reference model
    for (int i = 0; i < 40; i++) begin
      logic o;
      logic [W-1:0] a, b;
      o = 1'($urandom_range(0, 1));
      a = $urandom;
      case ($urandom_range(0, 3))
        0:       b = '0;
        1:       b = W'($urandom_range(1, 255));
        default: b = $urandom;
      endcase
      model(o, a, b, eh, el);
      run_op($sformatf("rand%0d", i), o, a, b, eh, el);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
